// File: rtl/psk4_phase_gen.sv
// PSK4 phase generator: symbol FIFO, NCO phase accumulator and QPSK offset, one registered angle per enabled sample.
// Define PSK4_DIFF_EN to build the differential (DQPSK) variant, where each symbol's offset accumulates.
module psk4_phase_gen #(
    parameter int SPS        = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int UCNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [31:0]       ftw,
    input  logic [1:0]        sym_data,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic [31:0]       angle,
    output logic              angle_valid,
    output logic              sym_strobe,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(SPS);

    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_n;

    // Symbol FIFO
    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // Phase datapath
    logic [31:0]       phase_acc, phase_acc_n;
    logic [31:0]       offset, offset_n;
    logic [31:0]       sym_offset;
    logic [31:0]       offset_upd;
    logic [CNT_W-1:0]  sample_cnt, sample_cnt_n;
    logic [31:0]       angle_n;
    logic              angle_valid_n;
    logic              sym_strobe_n;
    logic              underrun_n;
    logic [UCNT_W-1:0] underrun_cnt_n;

    function automatic logic [31:0] map_symbol(input logic [1:0] sym);
        case (sym)
            2'b00:   map_symbol = 32'h2000_0000;
            2'b01:   map_symbol = 32'h6000_0000;
            2'b11:   map_symbol = 32'hA000_0000;
            default: map_symbol = 32'hE000_0000;
        endcase
    endfunction

    assign fifo_empty = (fifo_count == '0);
    // Ready uses the pre-pop count, so a push into a full FIFO is refused even when a pop happens.
    assign sym_ready  = !rst && (fifo_count < DEPTH_C);
    assign push       = sym_valid && sym_ready;
    assign sym_offset = map_symbol(mem[rd_ptr]);

`ifdef PSK4_DIFF_EN
    assign offset_upd = offset + sym_offset;
`else
    assign offset_upd = sym_offset;
`endif

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_n        = state;
        pop            = 1'b0;
        phase_acc_n    = phase_acc;
        offset_n       = offset;
        sample_cnt_n   = sample_cnt;
        angle_n        = angle;
        angle_valid_n  = 1'b0;
        sym_strobe_n   = 1'b0;
        underrun_n     = 1'b0;
        underrun_cnt_n = underrun_cnt;

        case (state)
            IDLE: begin
                if (en && !fifo_empty) begin
                    state_n       = RUN;
                    pop           = 1'b1;
                    offset_n      = offset_upd;
                    sample_cnt_n  = CNT_W'(1);
                    phase_acc_n   = phase_acc + ftw;
                    angle_n       = phase_acc + offset_upd;
                    angle_valid_n = 1'b1;
                    sym_strobe_n  = 1'b1;
                end
            end

            RUN: begin
                if (en) begin
                    phase_acc_n  = phase_acc + ftw;
                    sample_cnt_n = (sample_cnt == CNT_LAST) ? '0 : sample_cnt + CNT_W'(1);
                    if (sample_cnt == '0) begin
                        if (!fifo_empty) begin
                            pop          = 1'b1;
                            offset_n     = offset_upd;
                            sym_strobe_n = 1'b1;
                        end else begin
                            underrun_n = 1'b1;
                            if (underrun_cnt != '1) begin
                                underrun_cnt_n = underrun_cnt + UCNT_W'(1);
                            end
                        end
                    end
                    // Old accumulator plus the offset that applies to this sample.
                    angle_n       = phase_acc + offset_n;
                    angle_valid_n = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase_acc    <= '0;
            offset       <= '0;
            sample_cnt   <= '0;
            angle        <= '0;
            angle_valid  <= 1'b0;
            sym_strobe   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
        end else begin
            state        <= state_n;
            phase_acc    <= phase_acc_n;
            offset       <= offset_n;
            sample_cnt   <= sample_cnt_n;
            angle        <= angle_n;
            angle_valid  <= angle_valid_n;
            sym_strobe   <= sym_strobe_n;
            underrun     <= underrun_n;
            underrun_cnt <= underrun_cnt_n;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; entries are only read after being written, so clearing pointers suffices.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sym_data;
        end
    end

endmodule

// File: tb/tb_psk4_phase_gen.sv
// Self-checking bench for psk4_phase_gen: directed scenarios plus randomized traffic against a queue-based model.
module tb_psk4_phase_gen;

    localparam int SPS        = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int UCNT_W     = 8;
    localparam int UMAX       = (1 << UCNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [31:0]       ftw;
    logic [1:0]        sym_data;
    logic              sym_valid;
    logic              sym_ready;
    logic [31:0]       angle;
    logic              angle_valid;
    logic              sym_strobe;
    logic              underrun;
    logic [UCNT_W-1:0] underrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    psk4_phase_gen #(
        .SPS       (SPS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .UCNT_W    (UCNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ftw         (ftw),
        .sym_data    (sym_data),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .angle       (angle),
        .angle_valid (angle_valid),
        .sym_strobe  (sym_strobe),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: symbol queue, accumulated phase, position within the current symbol.
    bit [1:0]  q[$];
    bit [31:0] m_phase, m_offset, m_angle;
    bit        m_run, m_valid, m_strobe, m_under, m_accept;
    int        m_pos, m_ucnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Gray symbols in constellation order 00,01,11,10 sit at 45 + 90*k degrees.
    function automatic bit [31:0] sym_phase(input bit [1:0] s);
        int k;
        k = (s == 2'b00) ? 0 : (s == 2'b01) ? 1 : (s == 2'b11) ? 2 : 3;
        return 32'h2000_0000 + 32'(k) * 32'h4000_0000;
    endfunction

    task automatic model_step();
        bit [1:0] s;
        m_accept = 1'b0;
        if (rst) begin
            q.delete();
            m_phase = 0; m_offset = 0; m_angle = 0; m_run = 0; m_pos = 0; m_ucnt = 0;
            m_valid = 0; m_strobe = 0; m_under = 0;
            return;
        end
        m_accept = sym_valid && (q.size() < FIFO_DEPTH);
        m_valid = 0; m_strobe = 0; m_under = 0;
        if (en && (m_run || q.size() > 0)) begin
            if (!m_run || m_pos == 0) begin
                if (q.size() > 0) begin
                    s = q.pop_front();
`ifdef PSK4_DIFF_EN
                    m_offset = m_offset + sym_phase(s);
`else
                    m_offset = sym_phase(s);
`endif
                    m_strobe = 1;
                end else begin
                    m_under = 1;
                    if (m_ucnt < UMAX) m_ucnt++;
                end
            end
            m_angle = m_phase + m_offset;
            m_phase = m_phase + ftw;
            m_valid = 1;
            m_run   = 1;
            m_pos   = (m_pos + 1) % SPS;
        end
        if (m_accept) q.push_back(sym_data);
    endtask

    task automatic cycle();
        #1;
        check("sym_ready", 32'(sym_ready), 32'(!rst && q.size() < FIFO_DEPTH));
        model_step();
        @(posedge clk);
        #1;
        check("angle", angle, m_angle);
        check("angle_valid", 32'(angle_valid), 32'(m_valid));
        check("sym_strobe", 32'(sym_strobe), 32'(m_strobe));
        check("underrun", 32'(underrun), 32'(m_under));
        check("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
    endtask

    task automatic push_idle(input logic [1:0] s);
        en = 1'b0; sym_data = s; sym_valid = 1'b1;
        cycle();
        sym_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; sym_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    logic [1:0]  t1_sym [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
`ifdef PSK4_DIFF_EN
    logic [31:0] t1_exp [5] = '{32'h2000_0000, 32'h8000_0000, 32'h2000_0000, 32'h0000_0000, 32'h2000_0000};
    logic [31:0] t6_exp [3] = '{32'h6000_0000, 32'hC000_0000, 32'h2000_0000};
`else
    logic [31:0] t1_exp [5] = '{32'h2000_0000, 32'h6000_0000, 32'hA000_0000, 32'hE000_0000, 32'h2000_0000};
    logic [31:0] t6_exp [3] = '{32'h6000_0000, 32'h6000_0000, 32'h6000_0000};
`endif

    initial begin
        rst = 1'b1; en = 1'b0; ftw = '0; sym_data = '0; sym_valid = 1'b0;
        repeat (3) cycle();
        check("rst_angle", angle, 32'h0);
        check("rst_valid", 32'(angle_valid), 32'h0);
        check("rst_ucnt", 32'(underrun_cnt), 32'h0);
        rst = 1'b0;

        // Four symbols with en low fill the FIFO; a fifth waits for the first pop.
        for (int i = 0; i < 4; i++) push_idle(t1_sym[i]);
        #1 check("full_ready", 32'(sym_ready), 32'h0);
        sym_data = 2'b00; sym_valid = 1'b1; en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (m_accept) sym_valid = 1'b0;
            check("t1_angle", angle, t1_exp[i / SPS]);
            check("t1_strobe", 32'(sym_strobe), 32'(i % SPS == 0));
        end
        cycle();
        check("dry_underrun", 32'(underrun), 32'h1);
        check("dry_ucnt", 32'(underrun_cnt), 32'h1);
        check("dry_angle", angle, 32'h2000_0000);
        cycle();
        check("dry_pulse", 32'(underrun), 32'h0);
        repeat (300 * SPS) cycle();
        check("ucnt_sat", 32'(underrun_cnt), 32'(UMAX));

        // Phase accumulation and wrap with the offset held through an underrun.
        do_reset();
        ftw = 32'h1000_0000;
        push_idle(2'b00);
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            check("wrap_angle", angle, 32'h2000_0000 + 32'(i) * 32'h1000_0000);
            check("wrap_valid", 32'(angle_valid), 32'h1);
        end

        // Reset mid-symbol with two symbols still queued.
        do_reset();
        ftw = 32'h0123_4567;
        push_idle(2'b01); push_idle(2'b10); push_idle(2'b11);
        en = 1'b1;
        repeat (3) cycle();
        rst = 1'b1;
        #1 check("midrst_ready", 32'(sym_ready), 32'h0);
        cycle();
        check("midrst_angle", angle, 32'h0);
        check("midrst_valid", 32'(angle_valid), 32'h0);
        rst = 1'b0;
        #1 check("midrst_ready_after", 32'(sym_ready), 32'h1);
        repeat (4) begin
            cycle();
            check("midrst_idle", 32'(angle_valid), 32'h0);
        end

        // Repeated 01 symbols: absolute or accumulated offset depending on build.
        do_reset();
        ftw = '0;
        repeat (3) push_idle(2'b01);
        en = 1'b1;
        for (int i = 0; i < 3 * SPS; i++) begin
            cycle();
            check("t6_angle", angle, t6_exp[i / SPS]);
        end

        // Randomized traffic with occasional resets and changing tuning words.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) ftw = $urandom;
            rst       = ($urandom % 200) == 0;
            en        = ($urandom % 4) != 0;
            sym_data  = 2'($urandom);
            sym_valid = ((n / 1000) % 2 == 0) ? ($urandom % 2 == 0) : ($urandom % 16 == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psk4_phase_gen.md
Name: psk4_phase_gen

Overview:
Upstream stage of the PSK4 transmitter. Accepts 2-bit QPSK symbols over a valid/ready handshake and buffers them in a small FIFO. Produces one 32-bit phase word per enabled clock, equal to the NCO phase accumulator plus the symbol phase offset. The phase word drives the angle input of the downstream CORDIC sine/cosine stage.
- Angle encoding: full circle = 2^32; 0x40000000 = 90°. Bits [31:30] give the quadrant, matching the CORDIC's quadrant decode.

Parameters:
SPS, 8, samples (clock enables) per symbol; legal range 2..256.
FIFO_DEPTH, 4, symbol FIFO entries; must be a power of 2, at least 2.
UCNT_W, 8, width of the saturating underrun counter.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
en  in  1  sample enable; phase advances only when high
ftw  in  32  frequency tuning word (carrier phase increment per sample)
sym_data  in  2  QPSK symbol, Gray coded
sym_valid  in  1  symbol present
sym_ready  out  1  FIFO not full
angle  out  32  phase word to CORDIC
angle_valid  out  1  angle is a new sample
sym_strobe  out  1  high on the sample that starts a new symbol
underrun  out  1  one-cycle pulse when the FIFO is empty at a symbol boundary
underrun_cnt  out  UCNT_W  saturating count of underruns

Behaviour:
- Reset (rst=1 at a clk edge), also when asserted mid-operation: FIFO emptied, phase_acc=0, sample_cnt=0, offset=0, state=IDLE.
- Output values during reset: angle=0, angle_valid=0, sym_strobe=0, underrun=0, underrun_cnt=0, sym_ready=0 while rst is high.
- Handshake: a write occurs when sym_valid && sym_ready.
  - sym_ready = !rst && (fifo_count < FIFO_DEPTH).
  - Writes are accepted regardless of en.
  - Simultaneous push and pop when full: the push is refused, because sym_ready is based on the pre-pop count.
  - Simultaneous push and pop when empty: no bypass; the pop sees empty.
- Symbol mapping (offset): 00→0x20000000 (45°), 01→0x60000000 (135°), 11→0xA0000000 (225°), 10→0xE0000000 (315°).
- State IDLE:
  - angle_valid=0.
  - Go to RUN when en=1 and the FIFO is non-empty. On that same cycle a symbol boundary occurs: pop the symbol, load offset, sample_cnt=1, phase_acc+=ftw.
- State RUN, en=1, each cycle:
  - phase_acc += ftw, modulo 2^32 (wraps silently).
  - sample_cnt advances and wraps from SPS-1 to 0. A boundary occurs when the pre-increment count is 0.
  - At a boundary with the FIFO non-empty: pop, load the new offset, sym_strobe=1.
  - At a boundary with the FIFO empty: underrun=1, underrun_cnt += 1 (saturates at all-ones), offset is held, state stays RUN.
- State RUN, en=0: all state is frozen; angle holds its value; angle_valid=0; no pops.
- Return from RUN to IDLE only via rst.
- Output register: angle = phase_acc_old + offset_new, computed modulo 2^32 and registered.
  - angle_valid = 1 one clock after the enabled cycle (latency 1).
  - sym_strobe and underrun are aligned with the same angle_valid cycle.
- First sample after reset therefore has angle = 0 + offset (phase_acc is pre-increment).

Optional Feature:
- Macro PSK4_DIFF_EN.
- When defined, DQPSK encoding is used: at each successful pop, offset = offset + map(sym) modulo 2^32. Reset value is offset=0, so the first symbol yields exactly map(sym).
- When undefined: offset = map(sym), absolute QPSK.
- Underrun behaviour is identical in both builds: offset is held and no accumulation occurs.

Test Plan:
- Reset, then ftw=0, en=1, SPS=8; push 00,01,11,10 → angle = 0x20000000 ×8, 0x60000000 ×8, 0xA0000000 ×8, 0xE0000000 ×8. sym_strobe on samples 0, 8, 16, 24.
- ftw=0x10000000, symbol 00 repeated → angles 0x20000000, 0x30000000, … 0xF0000000, then 0x00000000 (wrap), with no glitch in angle_valid.
- Push 4 symbols with en=0 → sym_ready=0 after the 4th. The 5th is held until the first pop after en=1.
- A single symbol, then the FIFO runs dry → at sample 8: underrun=1 for one cycle, underrun_cnt=1, angle offset stays 0x20000000. Drive 300 boundaries → underrun_cnt saturates at 255.
- Assert rst in the middle of a symbol (sample_cnt=3, FIFO count 2) → next cycle: angle=0, angle_valid=0, sym_ready=1, FIFO empty, IDLE.
- With PSK4_DIFF_EN, ftw=0, push 01,01,01 → offsets 0x60000000, 0xC0000000, 0x20000000 (wrapped).
